// File: rtl/dmem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : dmem_arb_pkg
// Desc     : Shared types and constants for the data-memory arbiter: FSM
//            state encoding, requester identities and the two length
//            encodings used by the core and the external interface.
// Revision : 1.0 - initial release
//============================================================================
package dmem_arb_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_e;

    // Requester identity
    typedef logic req_id_t;
    localparam req_id_t REQ_CORE = 1'b0;
    localparam req_id_t REQ_INTF = 1'b1;

    // Core load/store unit length encoding (wide accesses use small codes)
    localparam logic [1:0] CORE_LEN_WORD = 2'b00;
    localparam logic [1:0] CORE_LEN_HALF = 2'b01;
    localparam logic [1:0] CORE_LEN_BYTE = 2'b10;
    localparam logic [1:0] CORE_LEN_NONE = 2'b11;

    // External interface length encoding (wide accesses use large codes)
    localparam logic [1:0] INTF_LEN_NONE = 2'b00;
    localparam logic [1:0] INTF_LEN_BYTE = 2'b01;
    localparam logic [1:0] INTF_LEN_HALF = 2'b10;
    localparam logic [1:0] INTF_LEN_WORD = 2'b11;

    // Byte-lane masks, always anchored at lane 0
    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_we_decode.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : dmem_we_decode
// Desc     : Converts a requester identity and its length code into the
//            4-bit RAM byte write mask. Purely combinational.
// Revision : 1.0 - initial release
//============================================================================
module dmem_we_decode
    import dmem_arb_pkg::*;
(
    input  logic        req_id_i,
    input  logic [1:0]  len_i,
    output logic [3:0]  mask_o
);

    // Each requester has its own length encoding; both map onto low lanes
    always_comb begin
        mask_o = MASK_NONE;
        if (req_id_i == REQ_CORE) begin
            case (len_i)
                CORE_LEN_WORD: mask_o = MASK_WORD;
                CORE_LEN_HALF: mask_o = MASK_HALF;
                CORE_LEN_BYTE: mask_o = MASK_BYTE;
                default:       mask_o = MASK_NONE;
            endcase
        end else begin
            case (len_i)
                INTF_LEN_WORD: mask_o = MASK_WORD;
                INTF_LEN_HALF: mask_o = MASK_HALF;
                INTF_LEN_BYTE: mask_o = MASK_BYTE;
                default:       mask_o = MASK_NONE;
            endcase
        end
    end

endmodule : dmem_we_decode
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : dmem_arbiter
// Desc     : Two-port arbiter and access sequencer for the single-port data
//            RAM (registered read data). Core LSU and external interface
//            share the RAM through a req/gnt/rvalid handshake; every access
//            runs IDLE -> ACCESS (-> RESP for reads).
// Config   : DMEM_ARB_FIXED_PRIO_EN - when defined the interface always wins
//            ties; otherwise ties are broken round-robin.
// Revision : 1.0 - initial release
//============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_LENGTH    = 32,
    parameter int ADDRESS_LENGTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    // Core load/store unit
    input  logic                      core_req_i,
    input  logic                      core_wr_i,
    input  logic [ADDRESS_LENGTH-1:0] core_addr_i,
    input  logic [DATA_LENGTH-1:0]    core_wdata_i,
    input  logic [1:0]                core_len_i,
    output logic                      core_gnt_o,
    output logic                      core_rvalid_o,
    output logic [DATA_LENGTH-1:0]    core_rdata_o,
    // External interface memory controller
    input  logic                      intf_req_i,
    input  logic                      intf_wr_i,
    input  logic [ADDRESS_LENGTH-1:0] intf_addr_i,
    input  logic [DATA_LENGTH-1:0]    intf_wdata_i,
    input  logic [1:0]                intf_len_i,
    output logic                      intf_gnt_o,
    output logic                      intf_rvalid_o,
    output logic [DATA_LENGTH-1:0]    intf_rdata_o,
    // RAM macro
    output logic                      mem_en_o,
    output logic [3:0]                mem_we_o,
    output logic [ADDRESS_LENGTH-1:0] mem_addr_o,
    output logic [DATA_LENGTH-1:0]    mem_di_o,
    input  logic [DATA_LENGTH-1:0]    mem_do_i,
    // Status
    output logic                      busy_o
);

    arb_state_e                  state_q;
    req_id_t                     owner_q;
    logic                        wr_q;
    logic                        mem_en_q;
    logic [3:0]                  mem_we_q;
    logic [ADDRESS_LENGTH-1:0]   mem_addr_q;
    logic [DATA_LENGTH-1:0]      mem_di_q;
    logic                        core_rvalid_q;
    logic                        intf_rvalid_q;
    logic [DATA_LENGTH-1:0]      core_rdata_q;
    logic [DATA_LENGTH-1:0]      intf_rdata_q;
    logic                        busy_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    req_id_t                     last_winner_q;
`endif

    req_id_t                     win_id_d;
    logic                        win_wr_d;
    logic [ADDRESS_LENGTH-1:0]   win_addr_d;
    logic [DATA_LENGTH-1:0]      win_wdata_d;
    logic [1:0]                  win_len_d;
    logic [3:0]                  win_mask_d;
    logic                        grant_d;

    // Pick the winner; a lone requester always wins, ties go by policy
    always_comb begin
        win_id_d = REQ_CORE;
        if (core_req_i && intf_req_i) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            win_id_d = REQ_INTF;
`else
            win_id_d = (last_winner_q == REQ_INTF) ? REQ_CORE : REQ_INTF;
`endif
        end else if (intf_req_i) begin
            win_id_d = REQ_INTF;
        end
    end

    // Route the winner's request fields towards the latches
    always_comb begin
        win_wr_d    = core_wr_i;
        win_addr_d  = core_addr_i;
        win_wdata_d = core_wdata_i;
        win_len_d   = core_len_i;
        if (win_id_d == REQ_INTF) begin
            win_wr_d    = intf_wr_i;
            win_addr_d  = intf_addr_i;
            win_wdata_d = intf_wdata_i;
            win_len_d   = intf_len_i;
        end
    end

    dmem_we_decode u_we_decode (
        .req_id_i (win_id_d),
        .len_i    (win_len_d),
        .mask_o   (win_mask_d)
    );

    // Grant is combinational so the requester sees it in the acceptance cycle
    assign grant_d    = (state_q == IDLE) && (core_req_i || intf_req_i);
    assign core_gnt_o = grant_d && (win_id_d == REQ_CORE);
    assign intf_gnt_o = grant_d && (win_id_d == REQ_INTF);

    // Access sequencer: latches the winner, drives the RAM, captures read data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            owner_q       <= REQ_CORE;
            wr_q          <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 4'b0000;
            mem_addr_q    <= '0;
            mem_di_q      <= '0;
            core_rvalid_q <= 1'b0;
            intf_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            intf_rdata_q  <= '0;
            busy_q        <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_winner_q <= REQ_INTF;
`endif
        end else begin
            core_rvalid_q <= 1'b0;
            intf_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        owner_q    <= win_id_d;
                        wr_q       <= win_wr_d;
                        mem_addr_q <= win_addr_d;
                        mem_di_q   <= win_wdata_d;
                        // Mask is resolved now so ACCESS drives it straight from a flop
                        mem_we_q   <= win_wr_d ? win_mask_d : 4'b0000;
                        mem_en_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ACCESS;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_winner_q <= win_id_d;
`endif
                    end
                end
                ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 4'b0000;
                    if (wr_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // RAM output is valid now, one cycle after the enable
                    if (owner_q == REQ_CORE) begin
                        core_rdata_q  <= mem_do_i;
                        core_rvalid_q <= 1'b1;
                    end else begin
                        intf_rdata_q  <= mem_do_i;
                        intf_rvalid_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 4'b0000;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign mem_en_o      = mem_en_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_di_o      = mem_di_q;
    assign core_rvalid_o = core_rvalid_q;
    assign intf_rvalid_o = intf_rvalid_q;
    assign core_rdata_o  = core_rdata_q;
    assign intf_rdata_o  = intf_rdata_q;
    assign busy_o        = busy_q;

endmodule : dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the shared data memory (DFFRAM macro, one read/write port, registered read data). It arbitrates between the multicycle core's load/store unit and the external interface memory controller (SPI loader/debug path) using a req/gnt/rvalid handshake. It sequences each access as address phase then read-response phase, and converts each requester's length encoding into a byte write mask. It sits between both requesters and the RAM, and replaces the static core_select mux.

## Interface
- DATA_LENGTH, 32, data width of RAM and both requesters
- ADDRESS_LENGTH, 12, word address width of RAM
- clk  in  1  single clock for arbiter and RAM
- rst_n  in  1  asynchronous, active-low reset
- core_req / intf_req  in  1  access request; held with fields stable until gnt
- core_wr / intf_wr  in  1  1 = write, 0 = read
- core_addr / intf_addr  in  ADDRESS_LENGTH  word address
- core_wdata / intf_wdata  in  DATA_LENGTH  write data
- core_len / intf_len  in  2  access length (encodings below)
- core_gnt / intf_gnt  out  1  one-cycle accept pulse
- core_rvalid / intf_rvalid  out  1  one-cycle read-data-valid pulse
- core_rdata / intf_rdata  out  DATA_LENGTH  read data, held until that requester's next read completes
- mem_en  out  1  RAM enable
- mem_we  out  4  RAM byte write enables
- mem_addr  out  ADDRESS_LENGTH  RAM address
- mem_di  out  DATA_LENGTH  RAM write data
- mem_do  in  DATA_LENGTH  RAM read data, valid the cycle after mem_en
- busy  out  1  high in ACCESS or RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select a winner and assert its gnt combinationally in the same cycle.
  - Latch the winner's wr, addr, wdata, len and identity on that edge, then go to ACCESS.
- ACCESS:
  - Drive mem_en=1, mem_addr and mem_di from the latches.
  - mem_we = mask if wr=1, else 0000.
  - Next state: RESP for a read, IDLE for a write.
- RESP:
  - Load mem_do into the winner's rdata register and set its rvalid for the next cycle.
  - Return to IDLE.
- Arbitration: round-robin on ties. last_winner resets to intf, so core wins the first tie. A single requester always wins.
- Core length → mask: 00→1111, 01→0011, 10→0001, 11→0000.
- Interface length → mask: 00→0000, 01→0001, 10→0011, 11→1111.
- Masks always cover the low lanes; there is no address-offset lane shifting.
- Write with a 0000 mask: RAM cycle still runs with mem_en=1 and no bytes change. No rvalid.
- req deasserted before gnt: no access, no state change.
- mem_en and mem_we are 0 outside ACCESS. mem_addr and mem_di hold the last latched values.

## Timing
- Request accepted in cycle N (gnt=1).
- ACCESS is cycle N+1, when the RAM samples.
- Read: RESP is cycle N+2; rvalid=1 and rdata is valid in cycle N+3.
- Write: done at end of N+1; next gnt possible at cycle N+2.
- Read: next gnt possible at N+3, concurrently with rvalid.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Reset values: gnt 0, rvalid 0, rdata 0, mem_en 0, mem_we 0000, mem_addr 0, mem_di 0, busy 0, state IDLE, last_winner intf.
- Reset mid-access aborts the access: no rvalid is issued, and a partially issued write may or may not land.
- Both reqs rising in the same cycle as a rvalid: arbitration proceeds normally.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN defined: the interface requester always wins ties (boot/program load has priority), last_winner is unused, and the core can starve while the interface streams.
- Macro undefined: round-robin as above.

## Structure
- Package dmem_arb_pkg holds:
  - state enum (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10)
  - requester ID constants (REQ_CORE, REQ_INTF)
  - both length encodings as named constants
- Sub-module dmem_we_decode converts (requester ID, len) to the 4-bit mask; it is purely combinational.
- The FSM, arbitration and latches are in dmem_arbiter.

## Test plan
- Core writes 0xDEADBEEF, len 00, addr 0x010; core reads 0x010 → core_gnt at N, mem_we=1111 at N+1, core_rvalid at read-N+3 with 0xDEADBEEF.
- Interface byte write 0xAA, len 01, addr 0x020, over a word preset to 0x11223344 → read returns 0x112233AA.
- Both req held high, 4 accesses each → grants alternate core, intf, core, intf. With DMEM_ARB_FIXED_PRIO_EN defined → 4 intf grants first.
- Core write with len 11 → mem_en=1 and mem_we=0000; a subsequent read returns the unchanged word.
- rst_n low during RESP of a core read → core_rvalid stays 0, all outputs return to reset values, and the next request is granted normally.
- Intf read completes, then core read of a different word → intf_rdata holds its value while core_rdata updates.
